dphy_lane_hs_sequencer: RTL
===========================

# dphy_lane_hs_sequencer

Per-lane D-PHY burst sequencer between the DSI packet engine and one 8:1 lane serializer plus its LP IOBUF pair. It drives the LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trail → LP-11 transition with programmable timing in word-clock cycles. It streams payload bytes to the serializer over a valid/ready handshake. One instance is used per data lane, all clocked by the word clock.

## Interface
- g_t_lpx, default 2: LP-01 duration, in cycles (≥1).
- g_t_hs_prepare, default 2: LP-00 duration, in cycles (≥1).
- g_t_hs_zero, default 4: HS-zero (0x00) words before sync (≥1).
- g_t_hs_trail, default 3: trail words after the last payload byte (≥1).
- g_t_hs_exit, default 3: LP-11 hold before the next request is accepted (≥1).
- clk_dsi_i  in  1  word clock; all logic on the rising edge.
- rst_a_i  in  1  asynchronous, active-high reset.
- hs_req_i  in  1  request a burst; sampled only in IDLE.
- data_i  in  8  payload byte; bit 0 is transmitted first.
- data_valid_i  in  1  data_i valid.
- data_last_i  in  1  final byte of the burst, qualified by data_valid_i.
- data_ready_o  out  1  byte is accepted on (valid & ready).
- serdes_data_o  out  8  word to the serializer.
- serdes_oe_o  out  1  HS driver enable.
- lp_p_o, lp_n_o  out  1 each  LP line levels.
- lp_oe_o  out  1  LP driver enable.
- busy_o  out  1  high in every state except IDLE.
- underrun_o  out  1  one-cycle pulse when valid is low while ready is high.

## Operation
- States, in order: IDLE, LPX, PREPARE, HS_ZERO, SYNC, DATA, TRAIL, EXIT, then back to IDLE.
- IDLE: LP-11 (lp_p=1, lp_n=1, lp_oe=1), serdes_oe=0. On hs_req_i=1, go to LPX.
- LPX: LP-01 for g_t_lpx cycles.
- PREPARE: LP-00 for g_t_hs_prepare cycles.
- HS_ZERO: lp_oe=0, serdes_oe=1, serdes_data=0x00 for g_t_hs_zero cycles.
- SYNC: serdes_data=0xB8 for 1 cycle.
- DATA: each accepted byte appears on serdes_data_o.
- TRAIL: serdes_data = fill for g_t_hs_trail cycles. Fill is 0xFF if bit 7 of the last word sent was 0, else 0x00.
- EXIT: serdes_oe=0, lp_oe=1, LP-11 for g_t_hs_exit cycles, then IDLE.
- data_ready_o = 1 in SYNC, and in DATA until a byte with data_last_i has been accepted. It is 0 in every other state.
- Accepting a byte with data_last_i=1 moves the block to TRAIL.
- Underrun: data_valid_i=0 in any ready cycle. The block pulses underrun_o and moves to TRAIL. The fill is computed from the word currently on serdes_data_o, so an underrun in SYNC gives fill 0x00 because 0xB8 has bit 7 = 1.
- hs_req_i is ignored outside IDLE. A request held high through EXIT starts a new burst from the following IDLE cycle.
- One shared down-counter, width $clog2 of the largest timing parameter plus 1. It is loaded with parameter−1 on state entry; the state advances when the counter reaches 0.

## Timing
- All outputs are registered.
- Reset values: serdes_data_o=0x00, serdes_oe_o=0, lp_p_o=1, lp_n_o=1, lp_oe_o=1, data_ready_o=0, busy_o=0, underrun_o=0; state IDLE.
- Reset asserted mid-burst returns all outputs to the reset values immediately, asynchronously, without a trail.
- hs_req_i seen at edge n: LP-01 is visible from n+1, and busy_o=1 from n+1.
- Payload latency: a byte accepted at edge n is on serdes_data_o in cycle n+1.
- The byte accepted in SYNC follows 0xB8 with no gap.
- Valid-at-every-ready gives a gapless payload.
- Minimum burst length, request to IDLE: 1 + lpx + prepare + zero + 1 + N + trail + exit cycles, where N is the payload length.
- Simultaneous data_last_i and underrun cannot occur, because last requires valid.

## Structure
- Shared package dphy_pkg holds:
  - the state enum;
  - C_DPHY_SYNC = 8'hB8;
  - LP level constants LP11, LP01 and LP00.
- Sub-module dphy_timing_counter: loadable down-counter with zero flag. It is also reused by the clock-lane sequencer.
- Expected size: about 200 lines of RTL.

## Test plan
- Default parameters, req for 1 cycle, payload 0x11,0x22,0x33(last) with valid always high:
  - LP-01 ×2, LP-00 ×2;
  - then 0x00 ×4, 0xB8, 0x11, 0x22, 0x33 consecutively;
  - then fill 0xFF ×3 (bit 7 of 0x33 = 0), then LP-11 ×3;
  - busy_o falls at the IDLE cycle.
- Last byte 0x80: trail fill is 0x00 ×3.
- Valid low on the 3rd ready cycle: underrun_o pulses once, and the trail follows the 2nd byte with no stall.
- Reset asserted during DATA: outputs return to LP-11 with serdes_oe=0 in the same cycle, and no trail words follow.
- hs_req_i held high constantly: back-to-back bursts, each separated by exactly g_t_hs_exit LP-11 cycles plus 1 IDLE cycle.
- All timing parameters set to 1: the exact cycle-count sequence matches the formula in Timing.

Source files
------------

// File: rtl/dphy_pkg.sv
// Shared D-PHY lane definitions: sequencer states, sync word, LP line levels
// and small constant helpers used by the lane sequencers.
package dphy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LPX,
    ST_PREPARE,
    ST_HS_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL,
    ST_EXIT
  } dphy_state_e;

  localparam logic [7:0] C_DPHY_SYNC = 8'hB8;

  // LP levels packed as {lp_p, lp_n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  // Trail must be the complement of the final transmitted bit (bit 7 goes out last).
  function automatic logic [7:0] trail_fill(input logic [7:0] last_word);
    return last_word[7] ? 8'h00 : 8'hFF;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dphy_timing_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
// Shared by the data-lane and clock-lane sequencers for their phase timing.
module dphy_timing_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dphy_lane_hs_sequencer.sv
// Per-lane D-PHY HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync
// -> payload -> trail -> LP-11, with every output registered from the next state.
module dphy_lane_hs_sequencer
  import dphy_pkg::*;
#(
  parameter int g_t_lpx        = 2,
  parameter int g_t_hs_prepare = 2,
  parameter int g_t_hs_zero    = 4,
  parameter int g_t_hs_trail   = 3,
  parameter int g_t_hs_exit    = 3
) (
  input  logic        clk_dsi_i,
  input  logic        rst_a_i,
  input  logic        hs_req_i,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  input  logic        data_last_i,
  output logic        data_ready_o,
  output logic [7:0]  serdes_data_o,
  output logic        serdes_oe_o,
  output logic        lp_p_o,
  output logic        lp_n_o,
  output logic        lp_oe_o,
  output logic        busy_o,
  output logic        underrun_o,
  output dphy_state_e state_o
);

  localparam int C_T_MAX = max2(max2(max2(g_t_lpx, g_t_hs_prepare),
                                     max2(g_t_hs_zero, g_t_hs_trail)), g_t_hs_exit);
  localparam int C_CW    = $clog2(C_T_MAX) + 1;

  localparam logic [C_CW-1:0] C_LD_LPX   = C_CW'(g_t_lpx - 1);
  localparam logic [C_CW-1:0] C_LD_PREP  = C_CW'(g_t_hs_prepare - 1);
  localparam logic [C_CW-1:0] C_LD_ZERO  = C_CW'(g_t_hs_zero - 1);
  localparam logic [C_CW-1:0] C_LD_TRAIL = C_CW'(g_t_hs_trail - 1);
  localparam logic [C_CW-1:0] C_LD_EXIT  = C_CW'(g_t_hs_exit - 1);

  dphy_state_e     state_q, state_d;
  logic            cnt_load, cnt_zero;
  logic [C_CW-1:0] cnt_val;

  logic            accept;
  logic            ready_d, underrun_d, busy_d, serdes_oe_d, lp_oe_d;
  logic [1:0]      lp_d;
  logic [7:0]      serdes_data_d;

  dphy_timing_counter #(.W(C_CW)) u_timer (
    .clk      (clk_dsi_i),
    .rst      (rst_a_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Handshake: a byte transfers on a rising edge where data_valid_i and
  // data_ready_o are both high; ready low means data_i is ignored, and ready
  // high with valid low is an underrun that ends the payload.
  always_comb begin
    state_d    = state_q;
    accept     = data_ready_o & data_valid_i;
    underrun_d = data_ready_o & ~data_valid_i;

    case (state_q)
      ST_IDLE:    if (hs_req_i) state_d = ST_LPX;
      ST_LPX:     if (cnt_zero) state_d = ST_PREPARE;
      ST_PREPARE: if (cnt_zero) state_d = ST_HS_ZERO;
      ST_HS_ZERO: if (cnt_zero) state_d = ST_SYNC;
      ST_SYNC:    state_d = data_valid_i ? ST_DATA : ST_TRAIL;
      // After the last byte is accepted DATA lingers one cycle to show it.
      ST_DATA:    if (!data_ready_o || !data_valid_i) state_d = ST_TRAIL;
      ST_TRAIL:   if (cnt_zero) state_d = ST_EXIT;
      ST_EXIT:    if (cnt_zero) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    cnt_load = (state_d != state_q);
    case (state_d)
      ST_LPX:     cnt_val = C_LD_LPX;
      ST_PREPARE: cnt_val = C_LD_PREP;
      ST_HS_ZERO: cnt_val = C_LD_ZERO;
      ST_TRAIL:   cnt_val = C_LD_TRAIL;
      ST_EXIT:    cnt_val = C_LD_EXIT;
      default:    cnt_val = '0;
    endcase

    busy_d      = (state_d != ST_IDLE);
    ready_d     = (state_d == ST_SYNC) ||
                  ((state_d == ST_DATA) && data_ready_o && !(accept && data_last_i));
    lp_oe_d     = (state_d == ST_IDLE) || (state_d == ST_LPX) ||
                  (state_d == ST_PREPARE) || (state_d == ST_EXIT);
    serdes_oe_d = (state_d == ST_HS_ZERO) || (state_d == ST_SYNC) ||
                  (state_d == ST_DATA) || (state_d == ST_TRAIL);

    case (state_d)
      ST_LPX:     lp_d = LP01;
      ST_PREPARE: lp_d = LP00;
      ST_IDLE,
      ST_EXIT:    lp_d = LP11;
      default:    lp_d = LP00;
    endcase

    case (state_d)
      ST_SYNC:  serdes_data_d = C_DPHY_SYNC;
      ST_DATA:  serdes_data_d = accept ? data_i : serdes_data_o;
      // Fill is taken from the word on the wire when TRAIL is entered, then held.
      ST_TRAIL: serdes_data_d = (state_q == ST_TRAIL) ? serdes_data_o
                                                      : trail_fill(serdes_data_o);
      default:  serdes_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_dsi_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      state_q       <= ST_IDLE;
      serdes_data_o <= 8'h00;
      serdes_oe_o   <= 1'b0;
      lp_p_o        <= 1'b1;
      lp_n_o        <= 1'b1;
      lp_oe_o       <= 1'b1;
      data_ready_o  <= 1'b0;
      busy_o        <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      serdes_data_o <= serdes_data_d;
      serdes_oe_o   <= serdes_oe_d;
      lp_p_o        <= lp_d[1];
      lp_n_o        <= lp_d[0];
      lp_oe_o       <= lp_oe_d;
      data_ready_o  <= ready_d;
      busy_o        <= busy_d;
      underrun_o    <= underrun_d;
    end
  end

  assign state_o = state_q;

endmodule
